// File: rtl/axis_broadcaster_routed.sv
// Packet-routed AXI-Stream broadcaster: each input packet is copied into the
// per-output FIFOs selected by a destination mask latched on its first beat.
module axis_broadcaster_routed #(
    parameter int AXIS_BYTES    = 1,
    parameter int NUM_STREAMS   = 2,
    parameter int FIFO_DEPTH    = 4,
    parameter int DROP_CNT_BITS = 16
) (
    input  logic                                clk,
    input  logic                                aresetn,
    output logic                                axis_i_tready,
    input  logic                                axis_i_tvalid,
    input  logic                                axis_i_tlast,
    input  logic [AXIS_BYTES*8-1:0]             axis_i_tdata,
    input  logic [NUM_STREAMS-1:0]              axis_i_tdest_mask,
    input  logic [NUM_STREAMS-1:0]              axis_o_tready,
    output logic [NUM_STREAMS-1:0]              axis_o_tvalid,
    output logic [NUM_STREAMS-1:0]              axis_o_tlast,
    output logic [NUM_STREAMS*AXIS_BYTES*8-1:0] axis_o_tdata,
    output logic [DROP_CNT_BITS-1:0]            drop_count
);

    localparam int DW = AXIS_BYTES * 8;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    logic                     in_pkt_q, in_pkt_d;
    logic [NUM_STREAMS-1:0]   mask_q, mask_d;
    logic [DROP_CNT_BITS-1:0] drop_q, drop_d;

    logic [NUM_STREAMS-1:0]   eff_mask;
    logic [NUM_STREAMS-1:0]   full;
    logic [NUM_STREAMS-1:0]   push;
    logic [NUM_STREAMS-1:0]   pop;
    logic                     accept;

    // Only selected outputs can hold off the input; a zero mask is always ready.
    always_comb begin
        eff_mask      = in_pkt_q ? mask_q : axis_i_tdest_mask;
        axis_i_tready = aresetn && (&(~eff_mask | ~full));
        accept        = axis_i_tvalid && axis_i_tready;
        push          = accept ? eff_mask : '0;
    end

    always_comb begin
        in_pkt_d = in_pkt_q;
        mask_d   = mask_q;
        drop_d   = drop_q;
        if (accept) begin
            in_pkt_d = !axis_i_tlast;
            if (!in_pkt_q) begin
                mask_d = axis_i_tdest_mask;
            end
            if (axis_i_tlast && (eff_mask == '0) && (drop_q != '1)) begin
                drop_d = drop_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            in_pkt_q <= 1'b0;
            mask_q   <= '0;
            drop_q   <= '0;
        end else begin
            in_pkt_q <= in_pkt_d;
            mask_q   <= mask_d;
            drop_q   <= drop_d;
        end
    end

    assign drop_count = drop_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STREAMS; gi++) begin : g_out
            logic [DW:0]   mem [FIFO_DEPTH];
            logic [AW-1:0] wr_q, wr_d;
            logic [AW-1:0] rd_q, rd_d;
            logic [CW-1:0] cnt_q, cnt_d;

            assign full[gi]               = (cnt_q == CW'(FIFO_DEPTH));
            assign axis_o_tvalid[gi]      = (cnt_q != '0);
            assign pop[gi]                = axis_o_tvalid[gi] && axis_o_tready[gi];
            assign axis_o_tlast[gi]       = mem[rd_q][DW];
            assign axis_o_tdata[gi*DW +: DW] = mem[rd_q][DW-1:0];

            // Pointers wrap naturally because FIFO_DEPTH is a power of two.
            always_comb begin
                wr_d  = wr_q + AW'(push[gi]);
                rd_d  = rd_q + AW'(pop[gi]);
                cnt_d = cnt_q + CW'(push[gi]) - CW'(pop[gi]);
            end

            always_ff @(posedge clk or negedge aresetn) begin
                if (!aresetn) begin
                    wr_q  <= '0;
                    rd_q  <= '0;
                    cnt_q <= '0;
                end else begin
                    wr_q  <= wr_d;
                    rd_q  <= rd_d;
                    cnt_q <= cnt_d;
                end
            end

            always_ff @(posedge clk) begin
                if (push[gi]) begin
                    mem[wr_q] <= {axis_i_tlast, axis_i_tdata};
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_axis_broadcaster_routed.sv
// Directed scoreboard bench for axis_broadcaster_routed (3 outputs, depth 4).
module tb_axis_broadcaster_routed;

    localparam int NS = 3;

    logic          clk = 1'b0;
    logic          aresetn;
    logic          axis_i_tready;
    logic          axis_i_tvalid;
    logic          axis_i_tlast;
    logic [7:0]    axis_i_tdata;
    logic [NS-1:0] axis_i_tdest_mask;
    logic [NS-1:0] axis_o_tready;
    logic [NS-1:0] axis_o_tvalid;
    logic [NS-1:0] axis_o_tlast;
    logic [23:0]   axis_o_tdata;
    logic [15:0]   drop_count;

    axis_broadcaster_routed #(
        .AXIS_BYTES(1), .NUM_STREAMS(NS), .FIFO_DEPTH(4), .DROP_CNT_BITS(16)
    ) dut (
        .clk(clk), .aresetn(aresetn),
        .axis_i_tready(axis_i_tready), .axis_i_tvalid(axis_i_tvalid),
        .axis_i_tlast(axis_i_tlast), .axis_i_tdata(axis_i_tdata),
        .axis_i_tdest_mask(axis_i_tdest_mask),
        .axis_o_tready(axis_o_tready), .axis_o_tvalid(axis_o_tvalid),
        .axis_o_tlast(axis_o_tlast), .axis_o_tdata(axis_o_tdata),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    logic [8:0]    exp_q [NS][$];
    logic          tb_in_pkt = 1'b0;
    logic [NS-1:0] tb_mask   = '0;
    int            drop_exp  = 0;
    bit            throttle  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: every handshake pops the oldest expected beat of that stream.
    always @(negedge clk) begin
        if (aresetn === 1'b1) begin
            for (int i = 0; i < NS; i++) begin
                if (axis_o_tvalid[i] && axis_o_tready[i]) begin
                    chk($sformatf("o%0d_beat_expected", i), 32'(exp_q[i].size() != 0), 32'd1);
                    if (exp_q[i].size() != 0) begin
                        logic [8:0] e;
                        e = exp_q[i].pop_front();
                        chk($sformatf("o%0d_beat", i),
                            {23'd0, axis_o_tlast[i], axis_o_tdata[i*8 +: 8]}, {23'd0, e});
                    end
                end
            end
        end
    end

    // Alternate-cycle throttling of output 0.
    always begin
        @(posedge clk);
        #1;
        if (throttle) axis_o_tready[0] = ~axis_o_tready[0];
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_beat(input logic [7:0] d, input logic last, input logic [NS-1:0] m,
                             output int stalls);
        logic [NS-1:0] eff;
        bit done;
        done   = 0;
        stalls = 0;
        axis_i_tvalid     = 1'b1;
        axis_i_tdata      = d;
        axis_i_tlast      = last;
        axis_i_tdest_mask = m;
        while (!done) begin
            @(negedge clk);
            if (axis_i_tready) begin
                eff = tb_in_pkt ? tb_mask : m;
                for (int i = 0; i < NS; i++)
                    if (eff[i]) exp_q[i].push_back({last, d});
                if (!tb_in_pkt) tb_mask = m;
                if (last && eff == '0 && drop_exp < 65535) drop_exp++;
                tb_in_pkt = !last;
                done = 1;
            end else begin
                stalls++;
                if (stalls >= 64) begin
                    chk("input_accept_timeout", 32'(stalls), 32'd0);
                    done = 1;
                end
            end
            @(posedge clk);
            #1;
        end
        axis_i_tvalid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        int total;
        n = 0;
        total = exp_q[0].size() + exp_q[1].size() + exp_q[2].size();
        while (total != 0 && n < 200) begin
            @(posedge clk);
            n++;
            total = exp_q[0].size() + exp_q[1].size() + exp_q[2].size();
        end
        @(posedge clk);
        #1;
        chk({tag, "_residual"}, 32'(total), 32'd0);
        chk({tag, "_tvalid_idle"}, 32'(axis_o_tvalid), 32'd0);
    endtask

    initial begin
        int st;
        aresetn           = 1'b0;
        axis_i_tvalid     = 1'b0;
        axis_i_tlast      = 1'b0;
        axis_i_tdata      = '0;
        axis_i_tdest_mask = '0;
        axis_o_tready     = '1;

        // Reset state
        #2;
        chk("rst_tready", 32'(axis_i_tready), 32'd0);
        chk("rst_tvalid", 32'(axis_o_tvalid), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        repeat (3) @(posedge clk);
        #2 aresetn = 1'b1;
        #1 chk("post_rst_tready", 32'(axis_i_tready), 32'd1);
        @(posedge clk);
        #1;

        // Broadcast with 1-cycle latency
        send_beat(8'h11, 1'b0, 3'b111, st);
        chk("bc_latency_tvalid", 32'(axis_o_tvalid), 32'h7);
        chk("bc_latency_tdata", 32'(axis_o_tdata), 32'h111111);
        send_beat(8'h22, 1'b0, 3'b111, st);
        chk("bc_rate", 32'(st), 32'd0);
        send_beat(8'h33, 1'b1, 3'b111, st);
        chk("bc_rate", 32'(st), 32'd0);
        drain("bc");

        // Routing with mid-packet mask changes
        send_beat(8'hA0, 1'b0, 3'b010, st);
        send_beat(8'hA1, 1'b1, 3'b101, st);
        send_beat(8'hB0, 1'b0, 3'b101, st);
        send_beat(8'hB1, 1'b1, 3'b010, st);
        drain("route");

        // Backpressure decoupling: output 1 stalled
        axis_o_tready = 3'b101;
        for (int b = 0; b < 4; b++) begin
            send_beat(8'h40 + 8'(b), 1'b0, 3'b011, st);
            chk("bp_full_rate", 32'(st), 32'd0);
        end
        fork
            begin
                send_beat(8'h44, 1'b0, 3'b011, st);
                send_beat(8'h45, 1'b1, 3'b011, st);
            end
            begin
                @(negedge clk);
                chk("bp_tready_low", 32'(axis_i_tready), 32'd0);
                repeat (2) @(negedge clk);
                chk("bp_tready_still_low", 32'(axis_i_tready), 32'd0);
                chk("bp_o0_drained", 32'(axis_o_tvalid[0]), 32'd0);
                @(posedge clk);
                #1 axis_o_tready[1] = 1'b1;
            end
        join
        axis_o_tready = '1;
        drain("bp");

        // Zero mask: discarded, always ready, counted
        for (int p = 0; p < 2; p++) begin
            for (int b = 0; b < 5; b++) begin
                send_beat(8'hD0 + 8'(b), (b == 4), 3'b000, st);
                chk("zm_ready", 32'(st), 32'd0);
                chk("zm_no_tvalid", 32'(axis_o_tvalid), 32'd0);
            end
        end
        chk("zm_drop2", 32'(drop_count), 32'(drop_exp));
        chk("zm_drop2_abs", 32'(drop_count), 32'd2);
        axis_i_tvalid     = 1'b1;
        axis_i_tlast      = 1'b1;
        axis_i_tdest_mask = '0;
        repeat (65533) @(posedge clk);
        #1;
        drop_exp = 65535;
        chk("zm_drop_max", 32'(drop_count), 32'(drop_exp));
        repeat (4) @(posedge clk);
        #1;
        axis_i_tvalid = 1'b0;
        chk("zm_drop_sat", 32'(drop_count), 32'hFFFF);
        chk("zm_no_tvalid_bulk", 32'(axis_o_tvalid), 32'd0);

        // Wrap-around with throttled output 0
        axis_o_tready = 3'b110;
        throttle = 1;
        for (int b = 0; b < 20; b++)
            send_beat(8'h60 + 8'(b), (b == 19), 3'b001, st);
        throttle = 0;
        @(posedge clk);
        #1 axis_o_tready = '1;
        drain("wrap");

        // Asynchronous reset in the middle of a packet
        axis_o_tready = '0;
        send_beat(8'hC1, 1'b0, 3'b111, st);
        axis_i_tvalid     = 1'b1;
        axis_i_tdata      = 8'hC2;
        axis_i_tlast      = 1'b0;
        axis_i_tdest_mask = 3'b111;
        #2 aresetn = 1'b0;
        #1;
        chk("arst_tvalid", 32'(axis_o_tvalid), 32'd0);
        chk("arst_tready", 32'(axis_i_tready), 32'd0);
        axis_i_tvalid = 1'b0;
        for (int i = 0; i < NS; i++) exp_q[i].delete();
        tb_in_pkt = 1'b0;
        tb_mask   = '0;
        drop_exp  = 0;
        @(posedge clk);
        #3 aresetn = 1'b1;
        #1;
        chk("arst_drop_cleared", 32'(drop_count), 32'(drop_exp));
        chk("arst_tvalid_after", 32'(axis_o_tvalid), 32'd0);
        axis_o_tready = '1;
        @(posedge clk);
        #1;
        send_beat(8'hA5, 1'b1, 3'b001, st);
        chk("arst_new_sop_tvalid", 32'(axis_o_tvalid), 32'h1);
        drain("arst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/axis_broadcaster_routed.md
Name: axis_broadcaster_routed

Overview:
- Packet-routed AXI-Stream broadcaster: each input packet is copied to the subset of outputs selected by a per-packet destination mask.
- Each output has its own FIFO, so one slow consumer stalls the input only when its FIFO is full. The outputs do not run in lock-step.
- Sits between a packet source and several independent consumers, for example an Ethernet RX path fanning out to protocol handlers.

Parameters:
- AXIS_BYTES, 1, tdata width in bytes (tdata is AXIS_BYTES*8 bits).
- NUM_STREAMS, 2, number of output streams (1..32).
- FIFO_DEPTH, 4, entries per output FIFO; power of two, at least 2.
- DROP_CNT_BITS, 16, width of the dropped-packet counter.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- aresetn  in  1  asynchronous active-low reset.
- axis_i_tready  out  1  input ready.
- axis_i_tvalid  in  1  input valid.
- axis_i_tlast  in  1  input last beat of packet.
- axis_i_tdata  in  AXIS_BYTES*8  input data.
- axis_i_tdest_mask  in  NUM_STREAMS  destination mask; sampled only on the first beat of a packet.
- axis_o_tready  in  NUM_STREAMS  per-output ready.
- axis_o_tvalid  out  NUM_STREAMS  per-output valid.
- axis_o_tlast  out  NUM_STREAMS  per-output last.
- axis_o_tdata  out  NUM_STREAMS*AXIS_BYTES*8  output data; stream i occupies bits [(i+1)*AXIS_BYTES*8-1 -: AXIS_BYTES*8].
- drop_count  out  DROP_CNT_BITS  number of packets discarded because their mask was zero; saturating.

Behaviour:
- Reset (aresetn low, asynchronous):
  - All FIFOs empty; axis_o_tvalid = 0.
  - in_pkt = 0; latched mask = 0; drop_count = 0.
  - axis_i_tready is 0 while reset is asserted.
  - After release, axis_i_tready is driven from the empty FIFOs (1) on the next evaluation.
- Reset mid-packet: all partial data is discarded, both the FIFO contents and the half-delivered packet. No tlast is emitted.
- Packet framing: register in_pkt.
  - Set on any accepted beat with tlast = 0.
  - Cleared on an accepted beat with tlast = 1.
  - A beat accepted while in_pkt = 0 is a start-of-packet (SOP) beat.
- Effective mask:
  - eff_mask = axis_i_tdest_mask when in_pkt = 0.
  - eff_mask = latched mask when in_pkt = 1.
  - The mask is latched on every accepted SOP beat. Changes to axis_i_tdest_mask mid-packet are ignored.
- Ready: axis_i_tready = AND over i of (!eff_mask[i] || !full[i]), gated by reset. It may depend combinationally on axis_i_tdest_mask and on the full flags.
- Accept: on axis_i_tvalid && axis_i_tready, write {tlast, tdata} into FIFO i for every i with eff_mask[i] = 1, all in the same cycle.
  - Unselected FIFOs are not written.
  - An input beat is never partially delivered.
- Zero mask:
  - If eff_mask == 0, axis_i_tready = 1 and all beats of the packet are consumed and discarded.
  - drop_count increments by 1 on the accepted tlast beat of that packet.
  - drop_count saturates at all-ones.
- Output FIFO i (independent per stream):
  - axis_o_tvalid[i] = !empty[i].
  - Pop on axis_o_tvalid[i] && axis_o_tready[i].
  - Simultaneous push and pop when full: not possible, because a full FIFO blocks the push (ready excludes it). Simultaneous push and pop at other occupancies keeps the count unchanged.
  - Occupancy counter is log2(FIFO_DEPTH)+1 bits. Read and write pointers wrap modulo FIFO_DEPTH.
  - Output tvalid/tlast/tdata are driven from FIFO storage selected by the read pointer; no combinational path from the input.
- Latency: an accepted beat appears on a selected, empty output in the next cycle (1-cycle latency).
- Throughput: 1 beat/cycle when all selected consumers hold tready = 1.
- Ordering: beats on each output stay in input order. Packets are never interleaved on an output.
- AXI rules: once asserted, axis_o_tvalid[i] and its data stay stable until accepted.

Test Plan:
- Broadcast: NUM_STREAMS=3, FIFO_DEPTH=4. Send a 3-beat packet 0x11,0x22,0x33 with mask 3'b111 and all tready=1 -> each output shows 0x11,0x22,0x33 on consecutive cycles starting 1 cycle after acceptance, tlast on 0x33.
- Routing: mask 3'b010 on packet A (2 beats), then 3'b101 on packet B (2 beats). Toggle the mask input mid-packet -> output 1 receives only A; outputs 0 and 2 receive only B; the mid-packet mask change has no effect.
- Backpressure decoupling: mask 3'b011, output 1 tready=0, 6-beat stream -> 4 beats accepted at full rate. axis_i_tready drops after the 4th beat while output 0 drains all 4. Release output 1 -> the remaining 2 beats are accepted, and output 1 delivers all 6 in order.
- Zero mask: send two 5-beat packets with mask 0 -> axis_i_tready=1 throughout, no output tvalid, drop_count = 2. Force 2^16+3 drops -> drop_count holds at 0xFFFF.
- Wrap-around: FIFO_DEPTH=4, output throttled to accept on alternate cycles over 20 beats -> data order intact across pointer wrap and occupancy never exceeds 4.
- Async reset mid-packet: assert aresetn low between cycle edges during beat 2 of a 4-beat packet -> all axis_o_tvalid drop immediately. After release, drop_count = 0, and a new SOP with mask 3'b001 is routed correctly with no stale beats.
